// File: rtl/mag12_to_s14_framer_if.sv
// Sample-in / frame-out bundle between the 12b sign/magnitude link and the sequence decomposer.
// Pure wiring: no storage, no latency.
// Backpressure is carried by in_ready (towards the link) and out_ready (from the decomposer).
interface mag12_to_s14_framer_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      in_mag;
  logic             in_sign;
  logic [1:0]       in_phase;
  logic             out_valid;
  logic             out_ready;
  logic [13:0]      out_a;
  logic [13:0]      out_b;
  logic [13:0]      out_c;
  logic             seq_err;
  logic [CNT_W-1:0] frame_cnt;

  // Environment side: supplies samples, consumes frames.
  modport master (
    output in_valid, in_mag, in_sign, in_phase, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, seq_err, frame_cnt
  );

  // Framer side.
  modport slave (
    input  in_valid, in_mag, in_sign, in_phase, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, seq_err, frame_cnt
  );
endinterface

// File: rtl/mag12_to_s14_framer.sv
// Rebuilds 14b two's-complement A/B/C from serial 12b sign/magnitude samples into one registered frame.
// Latency: out_valid rises the cycle after phase C is accepted.
// Backpressure: in_ready drops while a frame is held; one bubble cycle follows every handoff.
module mag12_to_s14_framer #(
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  mag12_to_s14_framer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_WAIT_A = 2'd0,
    S_WAIT_B = 2'd1,
    S_WAIT_C = 2'd2,
    S_FULL   = 2'd3
  } state_t;

  state_t           r_state;
  logic [13:0]      r_hold_a;
  logic [13:0]      r_hold_b;
  logic [13:0]      r_out_a;
  logic [13:0]      r_out_b;
  logic [13:0]      r_out_c;
  logic             r_out_valid;
  logic             r_seq_err;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [13:0]      w_mag_ext;
  logic [13:0]      w_val;
  logic             w_unused_lsbs;

  // The two LSBs of the scaled magnitude carry no information.
  assign w_unused_lsbs = ^bus.in_mag[1:0];

  // Magnitude is x4 scaled: drop the LSBs, then negate for sign=1.
  // Negating zero gives zero, so a "negative zero" sample decodes to 0.
  assign w_mag_ext = {4'b0000, bus.in_mag[11:2]};
  assign w_val     = bus.in_sign ? (14'd0 - w_mag_ext) : w_mag_ext;

  // Samples are only refused while a completed frame waits for the consumer.
  assign w_in_ready = (r_state != S_FULL);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Phase-ordering FSM with registered frame outputs, error pulse and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_A;
      r_hold_a    <= '0;
      r_hold_b    <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_c     <= '0;
      r_out_valid <= 1'b0;
      r_seq_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_seq_err <= 1'b0;
      case (r_state)
        S_WAIT_A: begin
          if (w_accept) begin
            if (bus.in_phase == 2'd0) begin
              r_hold_a <= w_val;
              r_state  <= S_WAIT_B;
            end else begin
              r_seq_err <= 1'b1;
            end
          end
        end
        S_WAIT_B: begin
          if (w_accept) begin
            if (bus.in_phase == 2'd1) begin
              r_hold_b <= w_val;
              r_state  <= S_WAIT_C;
            end else if (bus.in_phase == 2'd0) begin
              // A repeated A restarts the frame with the newer sample.
              r_seq_err <= 1'b1;
              r_hold_a  <= w_val;
            end else begin
              r_seq_err <= 1'b1;
              r_state   <= S_WAIT_A;
            end
          end
        end
        S_WAIT_C: begin
          if (w_accept) begin
            if (bus.in_phase == 2'd2) begin
              r_out_a     <= r_hold_a;
              r_out_b     <= r_hold_b;
              r_out_c     <= w_val;
              r_out_valid <= 1'b1;
              r_state     <= S_FULL;
            end else if (bus.in_phase == 2'd0) begin
              r_seq_err <= 1'b1;
              r_hold_a  <= w_val;
              r_state   <= S_WAIT_B;
            end else begin
              r_seq_err <= 1'b1;
              r_state   <= S_WAIT_A;
            end
          end
        end
        S_FULL: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            r_state     <= S_WAIT_A;
          end
        end
        default: r_state <= S_WAIT_A;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_c     = r_out_c;
  assign bus.seq_err   = r_seq_err;
  assign bus.frame_cnt = r_frame_cnt;

endmodule
